// File: rtl/four_bit_down_counter.sv
// Down counter with parallel load, free-running or one-shot mode,
// a registered borrow pulse on wrap and a registered done flag.
module four_bit_down_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             In,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Mode,
   output logic [WIDTH-1:0] Q,
   output logic             Zero,
   output logic             Borrow,
   output logic             Done
);

   localparam logic StRun  = 1'b0;
   localparam logic StHalt = 1'b1;

   localparam logic [WIDTH-1:0] One = WIDTH'(1);
   localparam logic [WIDTH-1:0] Two = WIDTH'(2);

   logic             state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             borrow_q, borrow_d;

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      borrow_d = 1'b0;
      if (Load) begin
         q_d     = D;
         state_d = StRun;
      end else if (In && (state_q == StRun)) begin
         if (!Mode) begin
            q_d      = q_q - One;
            borrow_d = (q_q == '0);
         end else if (q_q >= Two) begin
            q_d = q_q - One;
         end else begin
            // One-shot never wraps: 1 or 0 both land on zero and expire.
            q_d     = '0;
            state_d = StHalt;
         end
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q  <= StRun;
         q_q      <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         borrow_q <= borrow_d;
      end
   end

   assign Q      = q_q;
   assign Zero   = (q_q == '0);
   assign Borrow = borrow_q;
   assign Done   = (state_q == StHalt);

`ifndef SYNTHESIS
   a_borrow_all_ones : assert property (@(posedge Clock) disable iff (!Clear)
      Borrow |-> (Q == '1));
   a_done_at_zero : assert property (@(posedge Clock) disable iff (!Clear)
      Done |-> Zero);
`endif

endmodule
